// File: rtl/decode_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : decode_operand_fetch
// Description : Operand-fetch / issue stage. Drives register-file read
//               addresses, bypasses same-cycle write-back data, blocks
//               RAW/WAW hazards with a per-register pending scoreboard and
//               registers one instruction plus operands toward execute over
//               a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_operand_fetch #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int OPW  = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_op,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic            in_use1,
  input  logic            in_use2,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_we,
  output logic [AW-1:0]   rf_ra1,
  output logic [AW-1:0]   rf_ra2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [OPW-1:0]  ex_op,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [AW-1:0]   ex_rd,
  output logic            ex_we,
  output logic [31:0]     stall_cnt
);

  logic [NREG-1:0] r_pend;
  logic [31:0]     r_stall_cnt;
  logic            r_ex_valid;
  logic [OPW-1:0]  r_ex_op;
  logic [XLEN-1:0] r_ex_pc;
  logic [XLEN-1:0] r_ex_imm;
  logic [XLEN-1:0] r_ex_rs1_val;
  logic [XLEN-1:0] r_ex_rs2_val;
  logic [AW-1:0]   r_ex_rd;
  logic            r_ex_we;

  logic            w_wb_hit1;
  logic            w_wb_hit2;
  logic            w_wb_hitd;
  logic            w_raw1;
  logic            w_raw2;
  logic            w_waw;
  logic            w_hazard;
  logic            w_fire;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;

  // Register-file read addresses follow the sources directly
  assign rf_ra1 = in_rs1;
  assign rf_ra2 = in_rs2;

  // A write-back in this cycle satisfies a pending register it targets
  assign w_wb_hit1 = wb_valid && (wb_rd == in_rs1);
  assign w_wb_hit2 = wb_valid && (wb_rd == in_rs2);
  assign w_wb_hitd = wb_valid && (wb_rd == in_rd);

  assign w_raw1   = in_use1 && (in_rs1 != '0) && r_pend[in_rs1] && !w_wb_hit1;
  assign w_raw2   = in_use2 && (in_rs2 != '0) && r_pend[in_rs2] && !w_wb_hit2;
  assign w_waw    = in_we && (in_rd != '0) && r_pend[in_rd] && !w_wb_hitd;
  assign w_hazard = w_raw1 || w_raw2 || w_waw;

  assign in_ready = !w_hazard && (!r_ex_valid || ex_ready);
  assign w_fire   = in_valid && in_ready;

  // Operand select: x0 reads zero, write-back bypass beats stale regfile data
  always_comb begin
    w_op1 = rf_rd1;
    w_op2 = rf_rd2;
    if (in_rs1 == '0)   w_op1 = '0;
    else if (w_wb_hit1) w_op1 = wb_data;
    if (in_rs2 == '0)   w_op2 = '0;
    else if (w_wb_hit2) w_op2 = wb_data;
  end

  // Scoreboard masks; bit 0 is stripped when applied so x0 never pends
  assign w_set_mask = (w_fire && in_we && (in_rd != '0)) ? (NREG'(1) << in_rd) : '0;
  assign w_clr_mask = (wb_valid && (wb_rd != '0)) ? (NREG'(1) << wb_rd) : '0;

  // Pending bits: set applied after clear so a younger producer wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= ((r_pend & ~w_clr_mask) | w_set_mask) & ~NREG'(1);
    end
  end

  // Saturating count of cycles a presented instruction is held by a hazard
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (in_valid && w_hazard && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  // Execute-side output register: load on fire, drop valid when consumed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex_valid   <= 1'b0;
      r_ex_op      <= '0;
      r_ex_pc      <= '0;
      r_ex_imm     <= '0;
      r_ex_rs1_val <= '0;
      r_ex_rs2_val <= '0;
      r_ex_rd      <= '0;
      r_ex_we      <= 1'b0;
    end else if (w_fire) begin
      r_ex_valid   <= 1'b1;
      r_ex_op      <= in_op;
      r_ex_pc      <= in_pc;
      r_ex_imm     <= in_imm;
      r_ex_rs1_val <= w_op1;
      r_ex_rs2_val <= w_op2;
      r_ex_rd      <= in_rd;
      r_ex_we      <= in_we;
    end else if (ex_ready) begin
      r_ex_valid   <= 1'b0;
    end
  end

  assign ex_valid   = r_ex_valid;
  assign ex_op      = r_ex_op;
  assign ex_pc      = r_ex_pc;
  assign ex_imm     = r_ex_imm;
  assign ex_rs1_val = r_ex_rs1_val;
  assign ex_rs2_val = r_ex_rs2_val;
  assign ex_rd      = r_ex_rd;
  assign ex_we      = r_ex_we;
  assign stall_cnt  = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_operand_fetch
// Description : Scoreboard bench for decode_operand_fetch. Stimulus pushes
//               hand-computed expected issue records; a monitor pops and
//               compares on every execute handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_operand_fetch;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_op;
  logic [63:0] in_pc;
  logic [63:0] in_imm;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic        in_use1;
  logic        in_use2;
  logic [4:0]  in_rd;
  logic        in_we;
  logic [4:0]  rf_ra1;
  logic [4:0]  rf_ra2;
  logic [63:0] rf_rd1;
  logic [63:0] rf_rd2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [7:0]  ex_op;
  logic [63:0] ex_pc;
  logic [63:0] ex_imm;
  logic [63:0] ex_rs1_val;
  logic [63:0] ex_rs2_val;
  logic [4:0]  ex_rd;
  logic        ex_we;
  logic [31:0] stall_cnt;

  decode_operand_fetch dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_pc      (in_pc),
    .in_imm     (in_imm),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_use1    (in_use1),
    .in_use2    (in_use2),
    .in_rd      (in_rd),
    .in_we      (in_we),
    .rf_ra1     (rf_ra1),
    .rf_ra2     (rf_ra2),
    .rf_rd1     (rf_rd1),
    .rf_rd2     (rf_rd2),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_op      (ex_op),
    .ex_pc      (ex_pc),
    .ex_imm     (ex_imm),
    .ex_rs1_val (ex_rs1_val),
    .ex_rs2_val (ex_rs2_val),
    .ex_rd      (ex_rd),
    .ex_we      (ex_we),
    .stall_cnt  (stall_cnt)
  );

  typedef struct {
    logic [7:0]  op;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] v1;
    logic [63:0] v2;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one instruction and queue the record it must eventually issue as
  task automatic set_in(input logic [7:0] op, input logic [63:0] pc,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic use1, input logic use2,
                        input logic [4:0] rd, input logic we,
                        input logic [63:0] d1, input logic [63:0] d2,
                        input logic [63:0] e1, input logic [63:0] e2);
    exp_t e;
    in_valid = 1'b1;
    in_op    = op;
    in_pc    = pc;
    in_imm   = pc + 64'h10;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_use1  = use1;
    in_use2  = use2;
    in_rd    = rd;
    in_we    = we;
    rf_rd1   = d1;
    rf_rd2   = d2;
    e.op = op; e.pc = pc; e.imm = pc + 64'h10;
    e.v1 = e1; e.v2 = e2; e.rd = rd; e.we = we;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every execute handshake consumes one expected record
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && ex_valid && ex_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_issue_pc", ex_pc, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("ex_op",      {56'h0, ex_op}, {56'h0, e.op});
          chk("ex_pc",      ex_pc,          e.pc);
          chk("ex_imm",     ex_imm,         e.imm);
          chk("ex_rs1_val", ex_rs1_val,     e.v1);
          chk("ex_rs2_val", ex_rs2_val,     e.v2);
          chk("ex_rd",      {59'h0, ex_rd}, {59'h0, e.rd});
          chk("ex_we",      {63'h0, ex_we}, {63'h0, e.we});
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_op = '0; in_pc = '0; in_imm = '0;
    in_rs1 = '0; in_rs2 = '0; in_use1 = 1'b0; in_use2 = 1'b0; in_rd = '0;
    in_we = 1'b0; rf_rd1 = '0; rf_rd2 = '0; wb_valid = 1'b0; wb_rd = '0;
    wb_data = '0; ex_ready = 1'b1;

    // Reset held with an instruction already presented
    set_in(8'h01, 64'h1000, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0,
           64'h11, 64'h22, 64'h11, 64'h22);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ex_valid", {63'h0, ex_valid}, 64'h0);
    chk("rst_stall_cnt", {32'h0, stall_cnt}, 64'h0);
    chk("rst_ex_pc", ex_pc, 64'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("pre_fire_ex_valid", {63'h0, ex_valid}, 64'h0);
    chk("post_rst_in_ready", {63'h0, in_ready}, 64'h1);
    step();

    // Producer of x5
    set_in(8'h02, 64'h2000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1,
           64'hAAAA, 64'hBBBB, 64'h0, 64'h0);
    @(negedge clk);
    chk("first_fire_ex_valid", {63'h0, ex_valid}, 64'h1);
    step();

    // RAW on x5: stall two cycles, then fire on the bypassed write-back
    set_in(8'h03, 64'h3000, 5'd5, 5'd6, 1'b1, 1'b0, 5'd8, 1'b0,
           64'h5555, 64'h66, 64'hDEAD_BEEF, 64'h66);
    @(negedge clk);
    chk("raw_in_ready_0", {63'h0, in_ready}, 64'h0);
    step();
    @(negedge clk);
    chk("raw_in_ready_1", {63'h0, in_ready}, 64'h0);
    step();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'hDEAD_BEEF;
    @(negedge clk);
    chk("raw_stall_cnt", {32'h0, stall_cnt}, 64'd2);
    chk("raw_wb_in_ready", {63'h0, in_ready}, 64'h1);
    step();
    wb_valid = 1'b0;

    // x0 sources read zero; writing x0 never creates a pending bit
    set_in(8'h04, 64'h4000, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1,
           64'h1234, 64'h1234, 64'h0, 64'h0);
    @(negedge clk);
    chk("x0_in_ready", {63'h0, in_ready}, 64'h1);
    step();
    set_in(8'h05, 64'h5000, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1,
           64'h1234, 64'h1234, 64'h0, 64'h0);
    @(negedge clk);
    chk("x0_no_stall", {63'h0, in_ready}, 64'h1);
    chk("x0_stall_cnt", {32'h0, stall_cnt}, 64'd2);
    step();

    // Backpressure for three cycles: stage holds, counter does not move
    ex_ready = 1'b0;
    set_in(8'h06, 64'h6000, 5'd9, 5'd10, 1'b1, 1'b1, 5'd11, 1'b0,
           64'h99, 64'hAA, 64'h99, 64'hAA);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {63'h0, in_ready}, 64'h0);
      chk("bp_ex_valid", {63'h0, ex_valid}, 64'h1);
      chk("bp_ex_pc", ex_pc, 64'h5000);
      chk("bp_stall_cnt", {32'h0, stall_cnt}, 64'd2);
      step();
    end
    ex_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {63'h0, in_ready}, 64'h1);
    step();

    // Full throughput: one issue per cycle
    for (int i = 0; i < 4; i++) begin
      set_in(8'h10 + 8'(i), 64'h7000 + 64'(i * 4), 5'(12 + i), 5'd0, 1'b1, 1'b0,
             5'd0, 1'b0, 64'h100 + 64'(i), 64'h0, 64'h100 + 64'(i), 64'h0);
      @(negedge clk);
      chk("tput_in_ready", {63'h0, in_ready}, 64'h1);
      chk("tput_ex_valid", {63'h0, ex_valid}, 64'h1);
      step();
    end

    // Same-cycle set and clear of x7: the younger producer keeps it pending
    set_in(8'h20, 64'h8000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1,
           64'h0, 64'h0, 64'h0, 64'h0);
    @(negedge clk);
    step();
    set_in(8'h21, 64'h8100, 5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1,
           64'h33, 64'h7070, 64'h33, 64'h77);
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'h77;
    @(negedge clk);
    chk("waw_cleared_in_ready", {63'h0, in_ready}, 64'h1);
    step();
    wb_valid = 1'b0;
    set_in(8'h22, 64'h8200, 5'd7, 5'd0, 1'b1, 1'b0, 5'd12, 1'b0,
           64'h7171, 64'h0, 64'h7777, 64'h0);
    @(negedge clk);
    chk("set_wins_in_ready", {63'h0, in_ready}, 64'h0);
    step();
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'h7777;
    @(negedge clk);
    chk("set_wins_release", {63'h0, in_ready}, 64'h1);
    chk("set_wins_stall_cnt", {32'h0, stall_cnt}, 64'd3);
    step();
    wb_valid = 1'b0;

    // Saturation of the stall counter
    set_in(8'h23, 64'h9000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1,
           64'h0, 64'h0, 64'h0, 64'h0);
    @(negedge clk);
    step();
    set_in(8'h24, 64'h9100, 5'd0, 5'd10, 1'b0, 1'b1, 5'd13, 1'b0,
           64'h0, 64'h1010, 64'h0, 64'hCAFE);
    @(negedge clk);
    chk("sat_in_ready", {63'h0, in_ready}, 64'h0);
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cnt;
    step();
    @(negedge clk);
    chk("sat_reach", {32'h0, stall_cnt}, 64'hFFFF_FFFF);
    step();
    step();
    @(negedge clk);
    chk("sat_hold", {32'h0, stall_cnt}, 64'hFFFF_FFFF);
    wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 64'hCAFE;
    #1;
    chk("sat_release_in_ready", {63'h0, in_ready}, 64'h1);
    step();
    wb_valid = 1'b0;
    in_valid = 1'b0;

    // Drain and confirm every expected record was issued
    repeat (3) step();
    chk("queue_drained", 64'(q.size()), 64'h0);
    chk("drain_ex_valid", {63'h0, ex_valid}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_operand_fetch.md
Name: decode_operand_fetch

Overview:
Operand-fetch and issue stage of the cmpe125 RISC-V pipeline. It sits directly upstream of the 32x64 decode register file: it drives the register-file read addresses and takes the combinational read data back. It also bypasses the write-back value, which the register file only commits on the next clock edge. A per-register scoreboard blocks RAW/WAW hazards, and the block registers one decoded instruction plus its operands toward execute over a valid/ready handshake.

Parameters:
XLEN, 64, data width of registers and operands
NREG, 32, number of architectural registers
AW, 5, register index width (log2 NREG)
OPW, 8, width of opaque control/opcode field passed through

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  decoded instruction present
in_ready  out  1  stage accepts instruction this cycle
in_op  in  OPW  control field, passed through
in_pc  in  XLEN  instruction PC, passed through
in_imm  in  XLEN  immediate, passed through
in_rs1  in  AW  source 1 index
in_rs2  in  AW  source 2 index
in_use1  in  1  instruction reads rs1
in_use2  in  1  instruction reads rs2
in_rd  in  AW  destination index
in_we  in  1  instruction writes rd
rf_ra1  out  AW  register-file read address 1 (= in_rs1, combinational)
rf_ra2  out  AW  register-file read address 2 (= in_rs2, combinational)
rf_rd1  in  XLEN  register-file read data 1, same cycle
rf_rd2  in  XLEN  register-file read data 2, same cycle
wb_valid  in  1  write-back this cycle (same signals drive regfile write port)
wb_rd  in  AW  write-back index
wb_data  in  XLEN  write-back data
ex_valid  out  1  issued instruction valid
ex_ready  in  1  execute accepts
ex_op, ex_pc, ex_imm  out  OPW/XLEN/XLEN  registered pass-through
ex_rs1_val, ex_rs2_val  out  XLEN  registered operands
ex_rd  out  AW  registered destination
ex_we  out  1  registered write enable
stall_cnt  out  32  hazard-stall cycle counter

Behaviour:
- Reset (async, reset_n=0): ex_valid=0; all ex_* fields=0; scoreboard pend[]=0; stall_cnt=0. in_ready is combinational and may go high immediately after reset release.
- Operand select, per source s:
  - s==0 gives 0.
  - Otherwise, if wb_valid && wb_rd==s, use wb_data (bypass).
  - Otherwise use rf_rdN.
  - Operands with use=0 are captured like any other but carry no hazard.
- Hazard, combinational:
  - RAW: a used, nonzero source with pend[s]=1 and no matching write-back this cycle.
  - WAW: in_we && in_rd!=0 && pend[rd] && !(wb_valid && wb_rd==in_rd).
- in_ready = !hazard && (!ex_valid || ex_ready). Accepting an instruction is "fire" = in_valid && in_ready.
- Output register, 1-cycle latency:
  - On fire, load all ex_* fields and set ex_valid=1.
  - Else if ex_ready, clear ex_valid; fields hold their values.
  - Else hold everything.
  - Back-to-back: when ex_valid && ex_ready && fire, a new instruction loads every cycle (full throughput).
- Scoreboard:
  - On fire with in_we && in_rd!=0, set pend[in_rd].
  - On wb_valid && wb_rd!=0, clear pend[wb_rd].
  - Same index set and cleared in one cycle: set wins, because the new producer is younger.
  - pend[0] is never set.
- Write-back to an index with pend=0 is legal: it clears nothing and still bypasses.
- stall_cnt increments by 1 each cycle with in_valid && hazard, and saturates at 0xFFFF_FFFF.
- Backpressure alone (ex_valid && !ex_ready) is not a hazard stall and is not counted.
- in_valid=0: no state change except write-back scoreboard clears.
- Reset mid-operation: the in-flight ex entry is dropped and all pending bits clear. Write-back may resume immediately after reset.

Test Plan:
- Reset with in_valid=1, then release: ex_valid=0 and stall_cnt=0 during reset. First fire occurs the cycle after release, with ex_valid=1 on the following edge.
- Issue rd=5 (we=1) then rs1=5 (use1=1): second instruction stalls with in_ready=0 and stall_cnt increments. Drive wb_valid=1, wb_rd=5, wb_data=0xDEAD_BEEF: it fires that cycle and ex_rs1_val=0xDEAD_BEEF.
- rs1=0, rs2=0 with rf_rd1/rf_rd2=0x1234: ex_rs1_val=ex_rs2_val=0. Issue rd=0 (we=1): pend stays clear and the next instruction reading x0 never stalls.
- Hold ex_ready=0 for 3 cycles with ex_valid=1: in_ready=0, ex_* stable, stall_cnt unchanged. With ex_ready=1 and in_valid=1 continuously, one instruction issues every cycle.
- Same-cycle set and clear: pend[7]=1, write-back for x7 arrives while a new rd=7 instruction fires (WAW cleared by the write-back). pend[7] stays 1, and a following reader of x7 stalls until the next write-back.
- Stall counter saturation: preload stall_cnt to 0xFFFF_FFFE through a hierarchical force and hold the hazard 3 cycles. Counter reads 0xFFFF_FFFF and stays there.
